dac_soft_mute_seq: RTL and testbench
====================================

# dac_soft_mute_seq

Soft-mute and configuration sequencer between the DSP output sample (`dout`) and the Audio DAC digital datapath input (`Data_in`, `ISI_SEL`, `MIS_SEL`). It applies a linear gain ramp on every un-mute and mute. Any change to the DAC ISI/MIS selection is deferred until the path is fully muted, so the DAC never switches mode with signal present. All state advances on the 48 kHz sample strobe (`div8_128_en` from the clock divider).

## Interface
Parameters:
- `DW`, 24: sample width, signed two's complement.
- `STEP`, 1: gain increment/decrement per ramp step; legal range 1..256.

Ports:
- `m_clk` in 1: system clock, 49.152 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fs_en` in 1: sample strobe, one `m_clk` cycle wide (`div8_128_en`).
- `din` in DW: signed sample from the DSP.
- `play_req` in 1: level; 1 requests un-muted playback.
- `isi_req` in 1: requested DAC ISI select.
- `mis_req` in 1: requested DAC MIS select.
- `dout` out DW: gained sample to DAC `Data_in`; registered.
- `isi_sel` out 1: applied ISI select to the DAC; registered.
- `mis_sel` out 1: applied MIS select to the DAC; registered.
- `state_o` out 2: encoding MUTED=0, RAMP_UP=1, PLAY=2, RAMP_DOWN=3.
- `busy` out 1: 1 in RAMP_UP or RAMP_DOWN.

## Operation
- Internal `gain` is 9 bits unsigned, range 0..256; 256 is unity.
- Nothing changes on cycles where `fs_en`=0. All registers update only on the `m_clk` edge where `fs_en`=1 (one "step" below).
- `cfg_ok` = (`isi_req`==`isi_sel`) && (`mis_req`==`mis_sel`).
- On each step: `dout` <= (`din` * `gain`) >>> 8, using the pre-update `gain`.
  - Product is DW+9 bits signed; the arithmetic shift truncates toward −∞.
  - Overflow is impossible: −2^23*256>>>8 = −2^23.
- MUTED, `gain`=0:
  - Each step loads `isi_sel`<=`isi_req` and `mis_sel`<=`mis_req`.
  - If `play_req` && `cfg_ok` (evaluated before the load), go to RAMP_UP.
  - A configuration change therefore costs one extra silent sample.
- RAMP_UP:
  - If !`play_req` || !`cfg_ok`, go to RAMP_DOWN; `gain` is unchanged on this step.
  - Otherwise `gain` <= min(`gain`+STEP, 256). Reaching 256 enters PLAY on the same edge.
- PLAY:
  - If !`play_req` || !`cfg_ok`, go to RAMP_DOWN; otherwise hold.
- RAMP_DOWN:
  - `gain` <= max(`gain`−STEP, 0). Reaching 0 enters MUTED on the same edge.
  - Always completes; `play_req` and `cfg_ok` are ignored until MUTED.
- `isi_sel`/`mis_sel` never change outside MUTED.
- Simultaneous `play_req` fall and config change: a single RAMP_DOWN, and the new config is applied in MUTED.

## Timing
- Reset values: `state_o`=0 (MUTED), `gain`=0, `dout`=0, `isi_sel`=0, `mis_sel`=0, `busy`=0.
- Reset mid-ramp or mid-PLAY forces the reset values immediately, without waiting for a ramp.
- Latency: `dout` is valid on the `m_clk` edge after the `fs_en` cycle, i.e. one `m_clk` of latency.
- Ramp duration with STEP=1:
  - 256 steps, 5.33 ms, from MUTED to full gain.
  - PLAY is entered 257 steps after the first step with `play_req`=1.
- `busy` and `state_o` are registered and change on the same edge as `gain`.

## Configuration
- Macro: `DAC_SOFT_MUTE_ZC_EN`.
- Defined (zero-cross stepping): in RAMP_UP/RAMP_DOWN a `gain` step occurs only when
  - sign(`din`) differs from the sign of the previous step's `din`, or
  - a 6-bit timeout counter reaches 63, i.e. the 64th step since the last gain change.
- Under zero-cross stepping:
  - The counter clears on every gain change and on entry to a ramp state.
  - Exit checks (RAMP_UP→RAMP_DOWN) are unaffected.
  - The previous-sign register resets to 0 (positive).
- Undefined: `gain` steps on every step; the counter and sign register are not built.

## Test plan
- Ramp up: reset, STEP=1, `play_req`=1, `din`=0x100000.
  - Step 1 → RAMP_UP, `dout`=0.
  - Step n (2..257) → `dout`=0x1000*(n−2); step 257 → PLAY.
  - Step 258 → `dout`=0x100000.
- Arithmetic at `gain`=128: `din`=−1 → `dout`=0xFFFFFF; `din`=3 → `dout`=1. At `gain`=256: `din`=0x800000 → `dout`=0x800000.
- Config change: in PLAY, toggle `isi_req`.
  - RAMP_DOWN for 256 steps with `isi_sel` unchanged.
  - MUTED step loads `isi_sel`; next step → RAMP_UP.
- Abort: drop `play_req` at `gain`=100 in RAMP_UP → RAMP_DOWN; reaches MUTED after exactly 100 steps. Reasserting `play_req` during RAMP_DOWN is ignored.
- Async reset: assert `rst_n`=0 mid-PLAY between strobes → all outputs 0 before the next `m_clk` edge.
- With `DAC_SOFT_MUTE_ZC_EN`:
  - Constant positive `din` → `gain` advances once per 64 steps.
  - Alternating-sign `din` → `gain` advances every step.

Source files
------------

// File: rtl/dac_soft_mute_seq_if.sv
// DSP-to-DAC sample/control bundle for the soft-mute sequencer.
// master drives samples and requests; slave returns gained sample, applied selects and status.
interface dac_soft_mute_seq_if #(
  parameter int DW = 24
);
  logic          fs_en;
  logic [DW-1:0] din;
  logic          play_req;
  logic          isi_req;
  logic          mis_req;
  logic [DW-1:0] dout;
  logic          isi_sel;
  logic          mis_sel;
  logic [1:0]    state_o;
  logic          busy;

  modport master (
    output fs_en, din, play_req, isi_req, mis_req,
    input  dout, isi_sel, mis_sel, state_o, busy
  );

  modport slave (
    input  fs_en, din, play_req, isi_req, mis_req,
    output dout, isi_sel, mis_sel, state_o, busy
  );
endinterface

// File: rtl/dac_soft_mute_seq.sv
// Soft-mute gain ramp and deferred ISI/MIS select update in front of the audio DAC datapath.
// Latency 1 m_clk after fs_en, no backpressure; optional zero-cross stepping via DAC_SOFT_MUTE_ZC_EN.
module dac_soft_mute_seq #(
  parameter int DW   = 24,
  parameter int STEP = 1
) (
  input  logic                  m_clk,
  input  logic                  rst_n,
  dac_soft_mute_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [8:0] GAIN_MAX = 9'd256;
  localparam logic [9:0] STEP_W   = 10'(STEP);

  state_t        state_q, state_d;
  logic [8:0]    gain_q, gain_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          isi_q, isi_d;
  logic          mis_q, mis_d;
  logic          busy_q, busy_d;

  logic                 cfg_ok;
  logic                 exit_req;
  logic                 step_ok;
  logic [9:0]           up_sum;
  logic [8:0]           gain_up;
  logic [8:0]           gain_dn;
  logic signed [DW+9:0] din_x;
  logic signed [DW+9:0] gain_x;
  logic signed [DW+9:0] prod;
  logic                 unused_prod_bits;

`ifdef DAC_SOFT_MUTE_ZC_EN
  logic [5:0] cnt_q, cnt_d;
  logic       sign_q, sign_d;
`endif

  // Taking bits [DW+7:8] of the full product is the arithmetic >>> 8 (floor toward -inf).
  always_comb begin
    din_x  = {{10{bus.din[DW-1]}}, bus.din};
    gain_x = {{(DW+1){1'b0}}, gain_q};
    prod   = din_x * gain_x;
    dout_d = prod[DW+7:8];
    unused_prod_bits = ^{prod[DW+9:DW+8], prod[7:0]};
  end

  always_comb begin
    cfg_ok   = (bus.isi_req == isi_q) && (bus.mis_req == mis_q);
    exit_req = !bus.play_req || !cfg_ok;
    up_sum   = {1'b0, gain_q} + STEP_W;
    gain_up  = (up_sum >= 10'd256) ? GAIN_MAX : up_sum[8:0];
    gain_dn  = ({1'b0, gain_q} <= STEP_W) ? 9'd0 : (gain_q - STEP_W[8:0]);
`ifdef DAC_SOFT_MUTE_ZC_EN
    step_ok  = (bus.din[DW-1] != sign_q) || (cnt_q == 6'd63);
`else
    step_ok  = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    isi_d   = isi_q;
    mis_d   = mis_q;
    case (state_q)
      MUTED: begin
        isi_d = bus.isi_req;
        mis_d = bus.mis_req;
        if (bus.play_req && cfg_ok) begin
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (exit_req) begin
          state_d = RAMP_DOWN;
        end else if (step_ok) begin
          gain_d = gain_up;
          if (gain_up == GAIN_MAX) begin
            state_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (exit_req) begin
          state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        // Ramp-down always runs to silence so a select change can never land mid-signal.
        if (step_ok) begin
          gain_d = gain_dn;
          if (gain_dn == 9'd0) begin
            state_d = MUTED;
          end
        end
      end
      default: state_d = MUTED;
    endcase
    busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

`ifdef DAC_SOFT_MUTE_ZC_EN
  always_comb begin
    sign_d = bus.din[DW-1];
    cnt_d  = cnt_q + 6'd1;
    if (!busy_d || (state_d != state_q) || (gain_d != gain_q)) begin
      cnt_d = 6'd0;
    end
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 6'd0;
      sign_q <= 1'b0;
    end else if (bus.fs_en) begin
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
    end
  end
`endif

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUTED;
      gain_q  <= 9'd0;
      dout_q  <= '0;
      isi_q   <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.fs_en) begin
      state_q <= state_d;
      gain_q  <= gain_d;
      dout_q  <= dout_d;
      isi_q   <= isi_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.isi_sel = isi_q;
  assign bus.mis_sel = mis_q;
  assign bus.state_o = state_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dac_soft_mute_seq.sv
// Directed bench for dac_soft_mute_seq (default build, STEP=1): ramps, arithmetic, config deferral, abort, async reset.
module tb_dac_soft_mute_seq;

  localparam int DW = 24;

  logic m_clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_v;

  dac_soft_mute_seq_if #(.DW(DW)) bus ();

  dac_soft_mute_seq #(.DW(DW), .STEP(1)) dut (
    .m_clk (m_clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial m_clk = 1'b0;
  always #10 m_clk = ~m_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One fs_en strobe followed by idle m_clk cycles; returns at a falling edge.
  task automatic step();
    @(negedge m_clk);
    bus.fs_en = 1'b1;
    @(negedge m_clk);
    bus.fs_en = 1'b0;
    repeat (3) @(negedge m_clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.fs_en    = 1'b0;
    bus.din      = '0;
    bus.play_req = 1'b0;
    bus.isi_req  = 1'b0;
    bus.mis_req  = 1'b0;
    repeat (3) @(negedge m_clk);

    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_dout",  32'(bus.dout),    32'd0);
    chk("rst_isi",   32'(bus.isi_sel), 32'd0);
    chk("rst_mis",   32'(bus.mis_sel), 32'd0);
    chk("rst_busy",  32'(bus.busy),    32'd0);

    rst_n = 1'b1;
    bus.play_req = 1'b1;
    bus.din = 24'h100000;
    step();
    chk("up1_state", 32'(bus.state_o), 32'd1);
    chk("up1_busy",  32'(bus.busy),    32'd1);
    chk("up1_dout",  32'(bus.dout),    32'd0);

    // din=3 lands on the step whose pre-update gain is 128
    for (int n = 2; n <= 257; n++) begin
      bus.din = (n == 130) ? 24'sd3 : 24'h100000;
      step();
      exp_v = (n == 130) ? 32'd1 : 32'h1000 * 32'(n - 2);
      chk("ramp_up_dout", 32'(bus.dout), exp_v);
      chk("ramp_up_state", 32'(bus.state_o), (n == 257) ? 32'd2 : 32'd1);
    end
    chk("play_busy", 32'(bus.busy), 32'd0);

    bus.din = 24'h100000;
    step();
    chk("play_dout", 32'(bus.dout), 32'h100000);
    bus.din = 24'h800000;
    step();
    chk("unity_neg_full", 32'(bus.dout), 32'h800000);
    chk("unity_state", 32'(bus.state_o), 32'd2);

    bus.din = 24'h100000;
    bus.isi_req = 1'b1;
    step();
    chk("cfg_enter_down", 32'(bus.state_o), 32'd3);
    chk("cfg_enter_dout", 32'(bus.dout), 32'h100000);
    chk("cfg_isi_hold", 32'(bus.isi_sel), 32'd0);

    // din=-1 lands on the step whose pre-update gain is 128
    for (int j = 1; j <= 256; j++) begin
      bus.din = (j == 129) ? 24'hFFFFFF : 24'h100000;
      step();
      exp_v = (j == 129) ? 32'hFFFFFF : 32'h1000 * 32'(257 - j);
      chk("ramp_dn_dout", 32'(bus.dout), exp_v);
      chk("ramp_dn_state", 32'(bus.state_o), (j == 256) ? 32'd0 : 32'd3);
      chk("ramp_dn_isi", 32'(bus.isi_sel), 32'd0);
    end

    bus.din = 24'h100000;
    step();
    chk("muted_load_isi", 32'(bus.isi_sel), 32'd1);
    chk("muted_load_state", 32'(bus.state_o), 32'd0);
    chk("muted_dout", 32'(bus.dout), 32'd0);
    step();
    chk("cfg_reup_state", 32'(bus.state_o), 32'd1);
    chk("cfg_reup_busy", 32'(bus.busy), 32'd1);

    for (int k = 1; k <= 100; k++) begin
      step();
    end
    chk("abort_pre_dout", 32'(bus.dout), 32'h63000);
    chk("abort_pre_state", 32'(bus.state_o), 32'd1);

    bus.play_req = 1'b0;
    step();
    chk("abort_state", 32'(bus.state_o), 32'd3);
    chk("abort_dout", 32'(bus.dout), 32'h64000);

    bus.play_req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("abort_dn_dout", 32'(bus.dout), 32'h1000 * 32'(101 - k));
      chk("abort_dn_state", 32'(bus.state_o), (k == 100) ? 32'd0 : 32'd3);
    end

    step();
    chk("replay_state", 32'(bus.state_o), 32'd1);
    for (int k = 1; k <= 256; k++) begin
      step();
    end
    chk("replay_play", 32'(bus.state_o), 32'd2);
    chk("replay_dout", 32'(bus.dout), 32'h0FF000);
    step();
    chk("replay_full", 32'(bus.dout), 32'h100000);

    @(negedge m_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state_o), 32'd0);
    chk("arst_dout",  32'(bus.dout),    32'd0);
    chk("arst_isi",   32'(bus.isi_sel), 32'd0);
    chk("arst_mis",   32'(bus.mis_sel), 32'd0);
    chk("arst_busy",  32'(bus.busy),    32'd0);

    @(negedge m_clk);
    rst_n = 1'b1;
    bus.play_req = 1'b0;
    step();
    chk("post_rst_state", 32'(bus.state_o), 32'd0);
    chk("post_rst_isi", 32'(bus.isi_sel), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
